// File: rtl/meter_pkg.sv
// -----------------------------------------------------------------------------
// meter_pkg
// Shared constants, the scan FSM state type and the LED bar helper for the
// multichannel peak meter.
//   SAMPLE_W     : audio word width (24-bit two's complement samples)
//   FULL_SCALE   : largest representable magnitude, also the clip threshold
//   LED_BASE_EXP : bar segment 0 lights at 2^LED_BASE_EXP (-48 dBFS)
//   LED_W        : number of bar segments (6 dB apart)
// -----------------------------------------------------------------------------
package meter_pkg;

    localparam int                  SAMPLE_W     = 24;
    localparam logic [SAMPLE_W-1:0] FULL_SCALE   = 24'd8388607;
    localparam int                  LED_BASE_EXP = 15;
    localparam int                  LED_W        = 8;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    // Thermometer bar: segment i lights when level >= 2^(LED_BASE_EXP+i),
    // which is the same as any bit at or above that position being set.
    // The top segment doubles as the clip indicator.
    function automatic logic [LED_W-1:0] led_bar(input logic [SAMPLE_W-1:0] level,
                                                 input logic                clipped);
        logic [LED_W-1:0] bar;
        for (int i = 0; i < LED_W; i++) begin
            bar[i] = (level >> (LED_BASE_EXP + i)) != '0;
        end
        bar[LED_W-1] = bar[LED_W-1] | clipped;
        return bar;
    endfunction

endpackage

// File: rtl/abs_sat.sv
// -----------------------------------------------------------------------------
// abs_sat
// Combinational saturating magnitude of a signed audio sample.
//   x   : signed SAMPLE_W-bit sample
//   mag : unsigned |x|, with the most negative code clamped to FULL_SCALE
// -----------------------------------------------------------------------------
module abs_sat
    import meter_pkg::*;
(
    input  logic signed [SAMPLE_W-1:0] x,
    output logic        [SAMPLE_W-1:0] mag
);

    function automatic logic [SAMPLE_W-1:0] sat_abs(input logic signed [SAMPLE_W-1:0] v);
        logic signed [SAMPLE_W-1:0] neg;
        logic        [SAMPLE_W-1:0] res;
        neg = -v;
        if (!v[SAMPLE_W-1]) begin
            res = v;
        end else if (neg[SAMPLE_W-1]) begin
            // Only the most negative code negates back onto itself.
            res = FULL_SCALE;
        end else begin
            res = neg;
        end
        return res;
    endfunction

    assign mag = sat_abs(x);

endmodule

// File: rtl/peak_meter.sv
// -----------------------------------------------------------------------------
// peak_meter
// Multichannel audio peak meter with peak hold, linear-in-log decay, sticky
// clip latches and an 8-segment bar for one selected channel. A captured
// frame is scanned one channel per clock through a single shared magnitude
// unit, so the meter costs one abs_sat regardless of NUM_CH.
//
// Parameters
//   NUM_CH      : channels metered
//   HOLD_FRAMES : frames a new peak is held before it starts to decay
//   DECAY_SHIFT : per-frame decay step is peak >> DECAY_SHIFT (minimum 1)
// Ports
//   clk, rst     : clock, synchronous active-high reset
//   sample_valid : one-cycle strobe, frame present on samples
//   samples      : NUM_CH signed 24-bit samples (channel k in samples[k])
//   sel          : channel shown on led
//   clip_clear   : one-cycle strobe, clears all clip latches
//   busy         : high while a frame is being scanned
//   frame_done   : one-cycle pulse in the last scan cycle of a frame
//   overrun      : sticky, a frame arrived while scanning and was dropped
//   peak         : metered level per channel (unsigned)
//   clip         : sticky clip latch per channel
//   led          : registered thermometer bar of peak[sel] / clip[sel]
// -----------------------------------------------------------------------------
module peak_meter
    import meter_pkg::*;
#(
    parameter int NUM_CH      = 8,
    parameter int HOLD_FRAMES = 4800,
    parameter int DECAY_SHIFT = 6
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            sample_valid,
    input  logic [NUM_CH-1:0][SAMPLE_W-1:0] samples,
    input  logic [$clog2(NUM_CH)-1:0]       sel,
    input  logic                            clip_clear,
    output logic                            busy,
    output logic                            frame_done,
    output logic                            overrun,
    output logic [NUM_CH-1:0][SAMPLE_W-1:0] peak,
    output logic [NUM_CH-1:0]               clip,
    output logic [LED_W-1:0]                led
);

    localparam int                 IDX_W      = $clog2(NUM_CH);
    localparam int                 HOLD_W     = $clog2(HOLD_FRAMES + 1);
    localparam logic [IDX_W-1:0]   LAST_IDX   = IDX_W'(NUM_CH - 1);
    localparam logic [IDX_W-1:0]   PENULT_IDX = IDX_W'(NUM_CH - 2);
    localparam logic [HOLD_W-1:0]  HOLD_LOAD  = HOLD_W'(HOLD_FRAMES);

    state_t                          state;
    logic [IDX_W-1:0]                idx;
    logic [NUM_CH-1:0][SAMPLE_W-1:0] frame_p0;
    logic [SAMPLE_W-1:0]             peak_mem [NUM_CH];
    logic [HOLD_W-1:0]               hold_mem [NUM_CH];

    logic                            vld_p1;
    logic signed [SAMPLE_W-1:0]      x_p1;
    logic [SAMPLE_W-1:0]             mag_p1;
    logic [SAMPLE_W-1:0]             pk_cur_p1;
    logic [SAMPLE_W-1:0]             pk_nxt_p1;
    logic [HOLD_W-1:0]               hd_cur_p1;
    logic [HOLD_W-1:0]               hd_nxt_p1;
    logic                            clip_hit_p1;
    logic [NUM_CH-1:0]               clip_set_p1;
    logic [LED_W-1:0]                led_nxt;

    // One decay step: subtract peak >> DECAY_SHIFT (at least 1 so small
    // peaks still reach zero), never dropping below the current magnitude.
    function automatic logic [SAMPLE_W-1:0] decay(input logic [SAMPLE_W-1:0] p,
                                                  input logic [SAMPLE_W-1:0] floor_lvl);
        logic [SAMPLE_W-1:0] step;
        logic [SAMPLE_W-1:0] nxt;
        step = p >> DECAY_SHIFT;
        if (step == '0) begin
            step = SAMPLE_W'(1);
        end
        nxt = (p > step) ? (p - step) : '0;
        return (nxt < floor_lvl) ? floor_lvl : nxt;
    endfunction

    // ---- stage p0: frame capture ----
    always_ff @(posedge clk) begin
        if (state == IDLE && sample_valid) begin
            frame_p0 <= samples;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            idx        <= '0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (sample_valid) begin
                        state <= SCAN;
                        idx   <= '0;
                        busy  <= 1'b1;
                    end
                end
                SCAN: begin
                    if (sample_valid) begin
                        overrun <= 1'b1;
                    end
                    if (idx == LAST_IDX) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        idx        <= idx + 1'b1;
                        // Registered, so it must be armed one cycle early to
                        // coincide with the last channel's scan cycle.
                        frame_done <= (idx == PENULT_IDX);
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // ---- stage p1: per-channel scan ----
    assign vld_p1    = (state == SCAN);
    assign x_p1      = frame_p0[idx];
    assign pk_cur_p1 = peak_mem[idx];
    assign hd_cur_p1 = hold_mem[idx];

    abs_sat u_abs_sat (
        .x   (x_p1),
        .mag (mag_p1)
    );

    always_comb begin
        pk_nxt_p1 = pk_cur_p1;
        hd_nxt_p1 = hd_cur_p1;
        if (mag_p1 >= pk_cur_p1) begin
            pk_nxt_p1 = mag_p1;
            hd_nxt_p1 = HOLD_LOAD;
        end else if (hd_cur_p1 != '0) begin
            hd_nxt_p1 = hd_cur_p1 - 1'b1;
        end else if (pk_cur_p1 != '0) begin
            pk_nxt_p1 = decay(pk_cur_p1, mag_p1);
        end
    end

    assign clip_hit_p1 = (mag_p1 >= FULL_SCALE);

    always_comb begin
        clip_set_p1 = '0;
        if (vld_p1 && clip_hit_p1) begin
            clip_set_p1[idx] = 1'b1;
        end
    end

    assign led_nxt = led_bar(peak_mem[sel], clip[sel]);

    // ---- stage p2: metering state write-back ----
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                peak_mem[i] <= '0;
                hold_mem[i] <= '0;
            end
            clip <= '0;
            led  <= '0;
        end else begin
            if (vld_p1) begin
                peak_mem[idx] <= pk_nxt_p1;
                hold_mem[idx] <= hd_nxt_p1;
            end
            // A channel clipping in the same cycle as a clear stays latched.
            clip <= (clip & ~{NUM_CH{clip_clear}}) | clip_set_p1;
            led  <= led_nxt;
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            peak[i] = peak_mem[i];
        end
    end

endmodule

// File: tb/tb_peak_meter.sv
`timescale 1ns/1ps
module tb_peak_meter;
    import meter_pkg::*;

    localparam int NUM_CH = 8;
    localparam int HOLD   = 200;
    localparam int DSH    = 6;

    logic                      clk = 1'b0;
    logic                      rst;
    logic                      sample_valid;
    logic [NUM_CH-1:0][23:0]   samples;
    logic [2:0]                sel;
    logic                      clip_clear;
    logic                      busy;
    logic                      frame_done;
    logic                      overrun;
    logic [NUM_CH-1:0][23:0]   peak;
    logic [NUM_CH-1:0]         clip;
    logic [7:0]                led;

    peak_meter #(.NUM_CH(NUM_CH), .HOLD_FRAMES(HOLD), .DECAY_SHIFT(DSH)) dut (
        .clk          (clk),
        .rst          (rst),
        .sample_valid (sample_valid),
        .samples      (samples),
        .sel          (sel),
        .clip_clear   (clip_clear),
        .busy         (busy),
        .frame_done   (frame_done),
        .overrun      (overrun),
        .peak         (peak),
        .clip         (clip),
        .led          (led)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference meter state
    int                 m_pk [NUM_CH];
    int                 m_hd [NUM_CH];
    logic [NUM_CH-1:0]  m_cl;

    typedef struct {
        logic [NUM_CH-1:0][23:0] pk;
        logic [NUM_CH-1:0]       cl;
    } exp_t;
    exp_t sb[$];

    function automatic int ref_mag(input logic [23:0] s);
        int v;
        v = int'($signed(s));
        if (v < 0) v = -v;
        if (v > 8388607) v = 8388607;
        return v;
    endfunction

    function automatic logic [7:0] ref_led(input int p, input logic c);
        logic [7:0] b;
        for (int i = 0; i < 8; i++) b[i] = (p >= (32768 << i));
        b[7] = b[7] | c;
        return b;
    endfunction

    function automatic void model_reset();
        for (int c = 0; c < NUM_CH; c++) begin
            m_pk[c] = 0;
            m_hd[c] = 0;
        end
        m_cl = '0;
        sb.delete();
    endfunction

    function automatic void model_frame(input logic [NUM_CH-1:0][23:0] s);
        exp_t e;
        int a, p, d;
        for (int c = 0; c < NUM_CH; c++) begin
            a = ref_mag(s[c]);
            p = m_pk[c];
            if (a >= p) begin
                p = a;
                m_hd[c] = HOLD;
            end else if (m_hd[c] > 0) begin
                m_hd[c] = m_hd[c] - 1;
            end else if (p > 0) begin
                d = p >> DSH;
                if (d < 1) d = 1;
                p = p - d;
                if (p < a) p = a;
            end
            m_pk[c] = p;
            if (a >= 8388607) m_cl[c] = 1'b1;
            e.pk[c] = 24'(p);
        end
        e.cl = m_cl;
        sb.push_back(e);
    endfunction

    // Drives one frame, optionally pulses clip_clear in scan cycle clr_at,
    // waits (bounded) for frame_done, then lets peak and led settle.
    task automatic drive_frame(input logic [NUM_CH-1:0][23:0] s, input int clr_at, output bit ok);
        int cyc;
        @(negedge clk);
        samples      = s;
        sample_valid = 1'b1;
        model_frame(s);
        @(negedge clk);
        sample_valid = 1'b0;
        cyc = 1;
        ok  = 1'b0;
        while (!ok && cyc < 20) begin
            clip_clear = (cyc == clr_at);
            if (frame_done) begin
                ok = 1'b1;
            end else begin
                @(negedge clk);
                cyc++;
            end
        end
        @(negedge clk);
        clip_clear = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; sample_valid = 1'b0; clip_clear = 1'b0; samples = '0; sel = 3'd0;
        repeat (2) @(negedge clk);
        // rst must win over a simultaneous frame strobe and clip clear
        sample_valid = 1'b1; clip_clear = 1'b1; samples = '1;
        @(negedge clk);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0b want 0", busy); end
        n_checks++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL reset_frame_done: got %0b want 0", frame_done); end
        n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL reset_overrun: got %0b want 0", overrun); end
        n_checks++; if (peak !== '0) begin n_fail++; $display("FAIL reset_peak: got %h want 0", peak); end
        n_checks++; if (clip !== '0) begin n_fail++; $display("FAIL reset_clip: got %b want 0", clip); end
        n_checks++; if (led !== 8'h00) begin n_fail++; $display("FAIL reset_led: got %h want 00", led); end
        sample_valid = 1'b0; clip_clear = 1'b0; samples = '0;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_basic();
        logic [NUM_CH-1:0][23:0] s;
        exp_t e;
        s = '0;
        s[0] = 24'hFFF000;  // -4096
        @(negedge clk);
        samples = s; sample_valid = 1'b1;
        model_frame(s);
        for (int cyc = 1; cyc <= 9; cyc++) begin
            @(negedge clk);
            sample_valid = 1'b0;
            n_checks++; if (busy !== (cyc <= 8)) begin n_fail++; $display("FAIL basic_busy cyc%0d: got %0b want %0b", cyc, busy, (cyc <= 8)); end
            n_checks++; if (frame_done !== (cyc == 8)) begin n_fail++; $display("FAIL basic_frame_done cyc%0d: got %0b want %0b", cyc, frame_done, (cyc == 8)); end
        end
        e = sb.pop_front();
        for (int c = 0; c < NUM_CH; c++) begin
            n_checks++; if (peak[c] !== e.pk[c]) begin n_fail++; $display("FAIL basic_peak ch%0d: got %0d want %0d", c, peak[c], e.pk[c]); end
        end
        n_checks++; if (peak[0] !== 24'd4096) begin n_fail++; $display("FAIL basic_peak0_abs: got %0d want 4096", peak[0]); end
    endtask

    task automatic test_hold_decay();
        logic [NUM_CH-1:0][23:0] s;
        exp_t e;
        bit ok;
        sel = 3'd0;
        s = '0;
        s[0] = 24'd1048576;
        for (int f = 0; f <= HOLD + 1; f++) begin
            drive_frame(s, -1, ok);
            s = '0;
            e = sb.pop_front();
            n_checks++; if (!ok) begin n_fail++; $display("FAIL hold_frame_done f%0d: got timeout want pulse", f); end
            for (int c = 0; c < NUM_CH; c++) begin
                n_checks++; if (peak[c] !== e.pk[c]) begin n_fail++; $display("FAIL hold_peak f%0d ch%0d: got %0d want %0d", f, c, peak[c], e.pk[c]); end
            end
            if (f == HOLD) begin
                n_checks++; if (peak[0] !== 24'd1048576) begin n_fail++; $display("FAIL hold_end: got %0d want 1048576", peak[0]); end
            end
        end
        n_checks++; if (peak[0] !== 24'd1032192) begin n_fail++; $display("FAIL hold_first_decay: got %0d want 1032192", peak[0]); end
    endtask

    task automatic test_clip();
        logic [NUM_CH-1:0][23:0] s;
        exp_t e;
        bit ok;
        sel = 3'd3;
        s = '0;
        s[3] = 24'h800000;  // -8388608
        drive_frame(s, -1, ok);
        e = sb.pop_front();
        n_checks++; if (peak[3] !== 24'd8388607) begin n_fail++; $display("FAIL clip_peak3: got %0d want 8388607", peak[3]); end
        n_checks++; if (clip !== e.cl) begin n_fail++; $display("FAIL clip_set: got %b want %b", clip, e.cl); end
        n_checks++; if (led !== 8'hFF) begin n_fail++; $display("FAIL clip_led: got %h want ff", led); end
        // ch5 clips in scan cycle 6, the same cycle clip_clear is high
        s = '0;
        s[5] = 24'h7FFFFF;
        m_cl = '0;
        drive_frame(s, 6, ok);
        e = sb.pop_front();
        n_checks++; if (clip !== 8'b0010_0000) begin n_fail++; $display("FAIL clip_clear_collide: got %b want 00100000", clip); end
        n_checks++; if (led !== ref_led(e.pk[3], e.cl[3])) begin n_fail++; $display("FAIL clip_led_after_clear: got %h want %h", led, ref_led(e.pk[3], e.cl[3])); end
        s = '0;
        for (int f = 0; f < 400 && m_pk[3] >= 4194304; f++) begin
            drive_frame(s, -1, ok);
            e = sb.pop_front();
            n_checks++; if (peak[3] !== e.pk[3]) begin n_fail++; $display("FAIL clip_decay_peak3 f%0d: got %0d want %0d", f, peak[3], e.pk[3]); end
            n_checks++; if (led !== ref_led(e.pk[3], e.cl[3])) begin n_fail++; $display("FAIL clip_decay_led f%0d: got %h want %h", f, led, ref_led(e.pk[3], e.cl[3])); end
        end
        n_checks++; if (peak[3] >= 24'd4194304) begin n_fail++; $display("FAIL clip_decayed: got %0d want below 4194304", peak[3]); end
        n_checks++; if (led[7] !== 1'b0) begin n_fail++; $display("FAIL clip_led7_off: got %0b want 0", led[7]); end
    endtask

    task automatic test_overrun();
        logic [NUM_CH-1:0][23:0] s1, s2;
        exp_t e;
        int dones;
        s1 = '0; s1[1] = 24'd1000;
        s2 = '0; s2[1] = 24'd5000000;
        @(negedge clk);
        samples = s1; sample_valid = 1'b1;
        model_frame(s1);
        dones = 0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (c == 4) begin
                n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL overrun_early: got %0b want 0", overrun); end
                samples = s2;
            end
            sample_valid = (c == 4);
            if (frame_done) dones++;
        end
        e = sb.pop_front();
        n_checks++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL overrun_set: got %0b want 1", overrun); end
        n_checks++; if (dones != 1) begin n_fail++; $display("FAIL overrun_done_count: got %0d want 1", dones); end
        for (int c = 0; c < NUM_CH; c++) begin
            n_checks++; if (peak[c] !== e.pk[c]) begin n_fail++; $display("FAIL overrun_peak ch%0d: got %0d want %0d", c, peak[c], e.pk[c]); end
        end
    endtask

    task automatic test_decay_floor();
        logic [NUM_CH-1:0][23:0] s;
        exp_t e;
        bit ok;
        int want;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL floor_rst_overrun: got %0b want 0", overrun); end
        rst = 1'b0;
        model_reset();
        sel = 3'd0;
        s = '0; s[0] = 24'd32;
        drive_frame(s, -1, ok);
        e = sb.pop_front();
        n_checks++; if (peak[0] !== 24'd32) begin n_fail++; $display("FAIL floor_load: got %0d want 32", peak[0]); end
        s = '0;
        for (int f = 0; f < HOLD; f++) begin
            drive_frame(s, -1, ok);
            e = sb.pop_front();
            n_checks++; if (peak[0] !== e.pk[0]) begin n_fail++; $display("FAIL floor_hold f%0d: got %0d want %0d", f, peak[0], e.pk[0]); end
        end
        for (int k = 1; k <= 34; k++) begin
            drive_frame(s, -1, ok);
            e = sb.pop_front();
            want = (k >= 32) ? 0 : 32 - k;
            n_checks++; if (peak[0] !== e.pk[0]) begin n_fail++; $display("FAIL floor_model k%0d: got %0d want %0d", k, peak[0], e.pk[0]); end
            n_checks++; if (peak[0] !== 24'(want)) begin n_fail++; $display("FAIL floor_step k%0d: got %0d want %0d", k, peak[0], want); end
            n_checks++; if (led[0] !== 1'b0) begin n_fail++; $display("FAIL floor_led0 k%0d: got %0b want 0", k, led[0]); end
        end
    endtask

    task automatic test_rst_mid_scan();
        logic [NUM_CH-1:0][23:0] s;
        exp_t e;
        bit ok;
        int dones;
        sel = 3'd2;
        s = '0; s[2] = 24'd2000000;
        drive_frame(s, -1, ok);
        e = sb.pop_front();
        n_checks++; if (led !== ref_led(e.pk[2], e.cl[2])) begin n_fail++; $display("FAIL rstmid_led_pre: got %h want %h", led, ref_led(e.pk[2], e.cl[2])); end
        s = '0; s[4] = 24'd3000000;
        @(negedge clk);
        samples = s; sample_valid = 1'b1;
        @(negedge clk);  // cycle 1
        sample_valid = 1'b0;
        @(negedge clk);  // cycle 2
        @(negedge clk);  // cycle 3
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy: got %0b want 0", busy); end
        n_checks++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL rstmid_frame_done: got %0b want 0", frame_done); end
        n_checks++; if (peak !== '0) begin n_fail++; $display("FAIL rstmid_peak: got %h want 0", peak); end
        n_checks++; if (clip !== '0) begin n_fail++; $display("FAIL rstmid_clip: got %b want 0", clip); end
        n_checks++; if (led !== 8'h00) begin n_fail++; $display("FAIL rstmid_led: got %h want 00", led); end
        dones = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (frame_done) dones++;
        end
        n_checks++; if (dones != 0) begin n_fail++; $display("FAIL rstmid_no_done: got %0d want 0", dones); end
        n_checks++; if (peak[4] !== 24'd0) begin n_fail++; $display("FAIL rstmid_peak4: got %0d want 0", peak[4]); end
        model_reset();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_hold_decay();
        test_clip();
        test_overrun();
        test_decay_floor();
        test_rst_mid_scan();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "simulation time limit reached");
    end

endmodule
